// File: rtl/tile_spawner.sv
// -----------------------------------------------------------------------------
// tile_spawner
//
// Purpose:
//   Inserts one new tile into the 2048 board after each accepted move.
//   On a request it snapshots the 64-bit board, starts at a pseudo-random cell
//   and walks forward (wrapping) to the first empty cell. It then issues one
//   write of exponent 1 (tile 2) or exponent 2 (tile 4). If the snapshot has
//   no empty cell, it skips the write. Instead it checks for any equal
//   orthogonal neighbour pair and raises game_over when there is none.
//
// Handshake:
//   spawn_req is a one-cycle request. It is sampled only while the FSM is in
//   IDLE, and requests seen in any other state are dropped. busy is high in
//   every non-IDLE state. done pulses once per accepted request. wr_en
//   coincides with done when a tile is written. wr_idx and wr_val are
//   meaningful only with wr_en and hold their last values otherwise.
//   The caller must not change the board while busy. Only the snapshot is used.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   board[63:0]  cell i = board[4i+3:4i], row = i[3:2], col = i[1:0], 0 = empty
//   spawn_req    one-cycle spawn request
//   busy         FSM not in IDLE
//   wr_en        one-cycle board write strobe
//   wr_idx[3:0]  cell index written
//   wr_val[3:0]  exponent written (1 or 2)
//   done         one-cycle completion pulse
//   game_over    sticky flag: full board with no possible merge
//   o_dbg_state  current FSM state (0 IDLE, 1 SCAN, 2 WRITE, 3 CHECK)
//   o_dbg_lfsr   current LFSR value
// -----------------------------------------------------------------------------
module tile_spawner #(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [3:0]  FOUR_THRESH = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] board,
  input  logic        spawn_req,
  output logic        busy,
  output logic        wr_en,
  output logic [3:0]  wr_idx,
  output logic [3:0]  wr_val,
  output logic        done,
  output logic        game_over,
  output logic [1:0]  o_dbg_state,
  output logic [15:0] o_dbg_lfsr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_WRITE = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_lfsr;
  logic [63:0] r_brd;
  logic [3:0]  r_ptr;
  logic        r_four;
  logic [3:0]  r_wr_idx;
  logic [3:0]  r_wr_val;
  logic        r_game_over;

  logic        w_board_full;
  logic        w_has_merge;
  logic        w_lfsr_fb;
  logic        w_cell_empty;
  logic [3:0]  w_cell;

  // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  // Cell under the scan pointer in the latched snapshot.
  assign w_cell       = r_brd[{r_ptr, 2'b00} +: 4];
  assign w_cell_empty = (w_cell == 4'd0);

  // The full-board decision is taken on the live board at accept time.
  // This guarantees that SCAN always finds an empty cell in the snapshot.
  always_comb begin
    w_board_full = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (board[4*i +: 4] == 4'd0) w_board_full = 1'b0;
    end
  end

  // Any equal orthogonal neighbour pair means a merge is still possible.
  always_comb begin
    w_has_merge = 1'b0;
    // Horizontal pairs: columns 0..2 against the cell to their right.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (r_brd[4*(4*r+c) +: 4] == r_brd[4*(4*r+c+1) +: 4]) w_has_merge = 1'b1;
      end
    end
    // Vertical pairs: rows 0..2 against the cell below.
    for (int i = 0; i < 12; i++) begin
      if (r_brd[4*i +: 4] == r_brd[4*(i+4) +: 4]) w_has_merge = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next state and state-decoded strobes. The strobes depend only on
  // r_state, so no input reaches an output combinationally.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    wr_en  = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (spawn_req) w_next = w_board_full ? S_CHECK : S_SCAN;
      end
      S_SCAN: begin
        busy = 1'b1;
        if (w_cell_empty) w_next = S_WRITE;
      end
      S_WRITE: begin
        busy   = 1'b1;
        wr_en  = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      S_CHECK: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: LFSR, snapshot, scan pointer, write data and game_over flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr      <= LFSR_SEED;
      r_brd       <= '0;
      r_ptr       <= '0;
      r_four      <= 1'b0;
      r_wr_idx    <= '0;
      r_wr_val    <= '0;
      r_game_over <= 1'b0;
    end else begin
      // Free-running, so the spawn position depends on request timing.
      r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
      unique case (r_state)
        S_IDLE: begin
          if (spawn_req) begin
            r_brd  <= board;
            r_ptr  <= r_lfsr[3:0];
            r_four <= (r_lfsr[7:4] < FOUR_THRESH);
          end
        end
        S_SCAN: begin
          if (w_cell_empty) begin
            r_wr_idx <= r_ptr;
            r_wr_val <= r_four ? 4'd2 : 4'd1;
          end else begin
            r_ptr <= r_ptr + 4'd1;
          end
        end
        S_WRITE: r_game_over <= 1'b0;
        S_CHECK: r_game_over <= ~w_has_merge;
        default: ;
      endcase
    end
  end

  assign wr_idx      = r_wr_idx;
  assign wr_val      = r_wr_val;
  assign game_over   = r_game_over;
  assign o_dbg_state = r_state;
  assign o_dbg_lfsr  = r_lfsr;

endmodule
